// File: rtl/dma_pkg.sv
// dma_pkg: shared types and constants for the DMA burst controller.
package dma_pkg;

  localparam int ADDR_W_DEF = 16;

  localparam logic DIR_RD = 1'b0;  // RAM -> output stream
  localparam logic DIR_WR = 1'b1;  // input stream -> RAM

  typedef enum logic [2:0] {
    IDLE,
    RD_RUN,
    RD_DRAIN,
    WR_RUN,
    DONE
  } dma_state_e;

endpackage

// File: rtl/dma_sync_fifo.sv
// dma_sync_fifo: small synchronous FIFO with combinational head read.
// DEPTH must be a power of two so the pointers wrap naturally.
module dma_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]         cnt_q;
  logic                    do_push, do_pop;

  assign full_o  = (cnt_q == CNTW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // Push into a full FIFO is accepted only when a pop frees the slot this cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNTW'(1);
        2'b01:   cnt_q <= cnt_q - CNTW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/dma_burst_ctrl.sv
// dma_burst_ctrl: burst engine between the byte-wide RAM and the CNN streams.
// dir=0 streams RAM bytes out through a credit-limited FIFO, dir=1 writes
// streamed bytes to RAM. Optional build macro DMA_CHECKSUM_EN adds a mod-256
// checksum output of the bytes transferred.
module dma_burst_ctrl
  import dma_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  input  logic              dir,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read_signal,
  output logic              mem_write_signal,
  output logic [7:0]        mem_data,
  input  logic [7:0]        mem_dataout,
  input  logic [7:0]        s_in_data,
  input  logic              s_in_valid,
  output logic              s_in_ready,
  output logic [7:0]        m_out_data,
  output logic              m_out_valid,
  input  logic              m_out_ready
`ifdef DMA_CHECKSUM_EN
  ,
  output logic [7:0]        checksum
`endif
);

  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW   = CNTW + 1;  // holds fifo_count + inflight without overflow

  dma_state_e        state_q;
  logic [ADDR_W-1:0] cur_addr_q, rem_q, addr_q;
  logic              busy_q, done_q, rd_q, wr_q;
  logic [7:0]        wdata_q;
  logic [RD_LAT-1:0] rd_pipe_q;

  logic [CNTW-1:0]   fifo_count;
  logic              fifo_full, fifo_empty;
  logic [7:0]        fifo_head;
  logic [CW-1:0]     inflight;
  logic              issue, push, pop, s_rdy, s_acc;

  // Read credit, stream handshakes and pipeline maturity.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(rd_pipe_q[i]);
    issue = (state_q == RD_RUN) && (rem_q != '0) && !fifo_full &&
            ((CW'(fifo_count) + inflight) < CW'(FIFO_DEPTH));
    push  = rd_pipe_q[RD_LAT-1];
    pop   = !fifo_empty && m_out_ready;
    s_rdy = (state_q == WR_RUN) && (rem_q != '0);
    s_acc = s_rdy && s_in_valid;
  end

  // Control FSM with registered strobes, address, write data, busy and done.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      rem_q      <= '0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
    end else begin
      done_q <= 1'b0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            cur_addr_q <= base_addr;
            rem_q      <= length;
            if (length == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= (dir == DIR_WR) ? WR_RUN : RD_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RD_RUN: begin
          if (issue) begin
            rd_q       <= 1'b1;
            addr_q     <= cur_addr_q;
            cur_addr_q <= cur_addr_q + ADDR_W'(1);
            rem_q      <= rem_q - ADDR_W'(1);
            if (rem_q == ADDR_W'(1)) state_q <= RD_DRAIN;
          end
        end
        RD_DRAIN: begin
          if (inflight == '0 && fifo_empty) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        WR_RUN: begin
          if (s_acc) begin
            wr_q       <= 1'b1;
            addr_q     <= cur_addr_q;
            wdata_q    <= s_in_data;
            cur_addr_q <= cur_addr_q + ADDR_W'(1);
            rem_q      <= rem_q - ADDR_W'(1);
          end
          // rem_q reaches 0 on the last accept; its write strobe is high this cycle.
          if (rem_q == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tracks issued reads until their data is capturable from the RAM.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      rd_pipe_q <= '0;
    end else begin
      rd_pipe_q[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
    end
  end

  dma_sync_fifo #(
    .W     (8),
    .DEPTH (FIFO_DEPTH)
  ) u_rd_fifo (
    .clk     (clk),
    .RST     (RST),
    .push_i  (push),
    .wdata_i (mem_dataout),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign busy             = busy_q;
  assign done             = done_q;
  assign mem_address      = addr_q;
  assign mem_read_signal  = rd_q;
  assign mem_write_signal = wr_q;
  assign mem_data         = wdata_q;
  assign s_in_ready       = s_rdy;
  assign m_out_data       = fifo_head;
  assign m_out_valid      = !fifo_empty;

`ifdef DMA_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  // Running sum of popped (read) or accepted (write) bytes, cleared per command.
  always_comb begin
    csum_d = csum_q;
    if (state_q == IDLE && start) csum_d = '0;
    else if (pop)                 csum_d = csum_q + fifo_head;
    else if (s_acc)               csum_d = csum_q + s_in_data;
  end

  // Checksum register.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) csum_q <= '0;
    else     csum_q <= csum_d;
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_dma_burst_ctrl.sv
// tb_dma_burst_ctrl: directed bench for dma_burst_ctrl with a negedge RAM model.
module tb_dma_burst_ctrl;

  logic        clk = 1'b0;
  logic        RST;
  logic        start, dir;
  logic [15:0] base_addr, length;
  logic        busy, done;
  logic [15:0] mem_address;
  logic        mem_read_signal, mem_write_signal;
  logic [7:0]  mem_data, mem_dataout;
  logic [7:0]  s_in_data;
  logic        s_in_valid, s_in_ready;
  logic [7:0]  m_out_data;
  logic        m_out_valid, m_out_ready;
`ifdef DMA_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dma_burst_ctrl dut (
    .clk              (clk),
    .RST              (RST),
    .start            (start),
    .dir              (dir),
    .base_addr        (base_addr),
    .length           (length),
    .busy             (busy),
    .done             (done),
    .mem_address      (mem_address),
    .mem_read_signal  (mem_read_signal),
    .mem_write_signal (mem_write_signal),
    .mem_data         (mem_data),
    .mem_dataout      (mem_dataout),
    .s_in_data        (s_in_data),
    .s_in_valid       (s_in_valid),
    .s_in_ready       (s_in_ready),
    .m_out_data       (m_out_data),
    .m_out_valid      (m_out_valid),
    .m_out_ready      (m_out_ready)
`ifdef DMA_CHECKSUM_EN
    ,
    .checksum         (checksum)
`endif
  );

  // RAM model (samples on negedge) plus stream/strobe monitor.
  logic [7:0]  ram [0:65535];
  logic [7:0]  ram_q = 8'h00;
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = 16'h0;
  logic [7:0]  pl_data = 8'h0;
  assign mem_dataout = ram_q;

  int cyc = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
  int both_viol = 0, credit_viol = 0, stall_viol = 0;
  int iss_tot = 0, pop_tot = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h0;
  logic [7:0]  outq[$];
  logic [15:0] rdaddrq[$];
  int          rdcycq[$];
  logic [15:0] wraddrq[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (pl_en) ram[pl_addr] <= pl_data;
    if (mem_write_signal) begin
      ram[mem_address] <= mem_data;
      wr_cnt <= wr_cnt + 1;
      wraddrq.push_back(mem_address);
    end
    if (mem_read_signal) begin
      ram_q <= ram[mem_address];
      rd_cnt <= rd_cnt + 1;
      rdaddrq.push_back(mem_address);
      rdcycq.push_back(cyc);
    end
    if (mem_read_signal && mem_write_signal) both_viol <= both_viol + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (RST) begin
      iss_tot    <= 0;
      pop_tot    <= 0;
      prev_stall <= 1'b0;
    end else begin
      if (iss_tot + int'(mem_read_signal) - pop_tot > 4) credit_viol <= credit_viol + 1;
      iss_tot <= iss_tot + int'(mem_read_signal);
      if (m_out_valid && m_out_ready) begin
        outq.push_back(m_out_data);
        pop_tot <= pop_tot + 1;
      end
      if (prev_stall && (!m_out_valid || m_out_data !== prev_data)) stall_viol <= stall_viol + 1;
      prev_stall <= m_out_valid && !m_out_ready;
      prev_data  <= m_out_data;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(negedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic do_start(input logic d, input logic [15:0] b, input logic [15:0] l);
    @(posedge clk); #1;
    start = 1'b1; dir = d; base_addr = b; length = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [37:0] outs;
    RST = 1'b1; start = 1'b0; dir = 1'b0; base_addr = '0; length = '0;
    s_in_data = '0; s_in_valid = 1'b0; m_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    outs = {busy, done, mem_address, mem_read_signal, mem_write_signal, mem_data,
            s_in_ready, m_out_data, m_out_valid};
    checks++;
    if (outs !== 38'd0) begin
      failures++; $display("FAIL reset_outputs: got %h want 0", outs);
    end
    RST = 1'b0;
    repeat (2) tick();
    checks++;
    if (busy !== 1'b0 || mem_read_signal !== 1'b0 || mem_write_signal !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset: busy=%b rd=%b wr=%b want 0", busy, mem_read_signal, mem_write_signal);
    end
  endtask

  task automatic test_read_burst();
    int o0, r0, rc0, d0;
    bit seen;
    logic [7:0] got;
    for (int i = 0; i < 8; i++) preload(16'h0100 + 16'(i), 8'(8'h10 + i));
    o0 = outq.size(); r0 = rdaddrq.size(); rc0 = rd_cnt; d0 = done_cnt;
    m_out_ready = 1'b1;
    do_start(1'b0, 16'h0100, 16'd8);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL rd_busy: got %b want 1", busy); end
    wait_done(100, seen);
    checks++;
    if (!seen) begin failures++; $display("FAIL rd_done: done=0 want pulse within 100 cycles"); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rd_busy_at_done: got %b want 0", busy); end
    tick();
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL rd_after_done: done=%b busy=%b want 0 0", done, busy);
    end
    checks++;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL rd_done_count: got %0d want 1", done_cnt - d0); end
    checks++;
    if (outq.size() - o0 != 8) begin failures++; $display("FAIL rd_out_count: got %0d want 8", outq.size() - o0); end
    for (int i = 0; i < 8; i++) begin
      got = (o0 + i < outq.size()) ? outq[o0 + i] : 8'hxx;
      checks++;
      if (got !== 8'(8'h10 + i)) begin failures++; $display("FAIL rd_byte%0d: got %h want %h", i, got, 8'(8'h10 + i)); end
    end
    checks++;
    if (rd_cnt - rc0 != 8) begin failures++; $display("FAIL rd_strobes: got %0d want 8", rd_cnt - rc0); end
    checks++;
    if (rdaddrq.size() - r0 != 8 || rdaddrq[r0] !== 16'h0100 || rdaddrq[r0 + 7] !== 16'h0107) begin
      failures++; $display("FAIL rd_addrs: first/last not 0100/0107");
    end
    checks++;
    if (rdcycq.size() - r0 != 8 || rdcycq[r0 + 7] - rdcycq[r0] != 7) begin
      failures++; $display("FAIL rd_consecutive: strobes not in 8 consecutive cycles");
    end
`ifdef DMA_CHECKSUM_EN
    checks++;
    if (checksum !== 8'h9C) begin failures++; $display("FAIL rd_checksum: got %h want 9c", checksum); end
`endif
  endtask

  task automatic test_backpressure();
    int o0, rc0, cv0, sv0;
    bit seen;
    logic [3:0] pat;
    logic [7:0] got;
    pat = 4'b1001;
    o0 = outq.size(); rc0 = rd_cnt; cv0 = credit_viol; sv0 = stall_viol;
    m_out_ready = 1'b1;
    do_start(1'b0, 16'h0100, 16'd8);
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      m_out_ready = pat[c % 4];
      @(negedge clk);
      if (done) seen = 1'b1;
      @(posedge clk); #1;
    end
    m_out_ready = 1'b1;
    checks++;
    if (!seen) begin failures++; $display("FAIL bp_done: no done within 200 cycles"); end
    checks++;
    if (outq.size() - o0 != 8) begin failures++; $display("FAIL bp_out_count: got %0d want 8", outq.size() - o0); end
    for (int i = 0; i < 8; i++) begin
      got = (o0 + i < outq.size()) ? outq[o0 + i] : 8'hxx;
      checks++;
      if (got !== 8'(8'h10 + i)) begin failures++; $display("FAIL bp_byte%0d: got %h want %h", i, got, 8'(8'h10 + i)); end
    end
    checks++;
    if (rd_cnt - rc0 != 8) begin failures++; $display("FAIL bp_strobes: got %0d want 8", rd_cnt - rc0); end
    checks++;
    if (credit_viol != cv0) begin failures++; $display("FAIL bp_credit: %0d cycles over 4 outstanding, want 0", credit_viol - cv0); end
    checks++;
    if (stall_viol != sv0) begin failures++; $display("FAIL bp_stable: %0d stalled-data changes, want 0", stall_viol - sv0); end
  endtask

  task automatic test_write_burst();
    int wc0, w0, d0;
    bit acc, seen;
    wc0 = wr_cnt; w0 = wraddrq.size(); d0 = done_cnt;
    do_start(1'b1, 16'h0200, 16'd4);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin s_in_valid = 1'b0; tick(); end
      s_in_valid = 1'b1; s_in_data = 8'(8'hA0 + i);
      acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++) begin
        @(negedge clk);
        acc = s_in_ready;
        tick();
      end
      checks++;
      if (!acc) begin failures++; $display("FAIL wr_accept%0d: s_in_ready=0 want 1 within 20 cycles", i); end
    end
    s_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (s_in_ready !== 1'b0) begin failures++; $display("FAIL wr_ready_after_last: got %b want 0", s_in_ready); end
    wait_done(50, seen);
    checks++;
    if (!seen) begin failures++; $display("FAIL wr_done: no done within 50 cycles"); end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ram[16'h0200 + 16'(i)] !== 8'(8'hA0 + i)) begin
        failures++; $display("FAIL wr_ram%0d: got %h want %h", i, ram[16'h0200 + 16'(i)], 8'(8'hA0 + i));
      end
    end
    checks++;
    if (wr_cnt - wc0 != 4) begin failures++; $display("FAIL wr_strobes: got %0d want 4", wr_cnt - wc0); end
    checks++;
    if (wraddrq.size() - w0 != 4 || wraddrq[w0] !== 16'h0200 || wraddrq[w0 + 3] !== 16'h0203) begin
      failures++; $display("FAIL wr_addrs: first/last not 0200/0203");
    end
    checks++;
    if (done_cnt - d0 != 1 || both_viol != 0) begin
      failures++; $display("FAIL wr_done_count: done=%0d overlap=%0d want 1 0", done_cnt - d0, both_viol);
    end
`ifdef DMA_CHECKSUM_EN
    checks++;
    if (checksum !== 8'h86) begin failures++; $display("FAIL wr_checksum: got %h want 86", checksum); end
`endif
  endtask

  task automatic test_len_zero();
    int rc0, wc0;
    rc0 = rd_cnt; wc0 = wr_cnt;
    do_start(1'b0, 16'h0400, 16'd0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL len0_done: done=%b busy=%b want 1 0", done, busy);
    end
    tick();
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL len0_pulse: done=%b want 0", done); end
    repeat (3) tick();
    checks++;
    if (rd_cnt != rc0 || wr_cnt != wc0) begin
      failures++; $display("FAIL len0_strobes: rd=%0d wr=%0d want 0 0", rd_cnt - rc0, wr_cnt - wc0);
    end
  endtask

  task automatic test_wrap();
    int o0, r0;
    bit seen;
    logic [15:0] exp_a [4];
    logic [7:0]  exp_d [4];
    logic [15:0] ga;
    logic [7:0]  gd;
    exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    exp_d = '{8'h5E, 8'h5F, 8'h60, 8'h61};
    for (int i = 0; i < 4; i++) preload(exp_a[i], exp_d[i]);
    o0 = outq.size(); r0 = rdaddrq.size();
    m_out_ready = 1'b1;
    do_start(1'b0, 16'hFFFE, 16'd4);
    wait_done(100, seen);
    checks++;
    if (!seen) begin failures++; $display("FAIL wrap_done: no done within 100 cycles"); end
    tick();
    for (int i = 0; i < 4; i++) begin
      ga = (r0 + i < rdaddrq.size()) ? rdaddrq[r0 + i] : 16'hxxxx;
      gd = (o0 + i < outq.size()) ? outq[o0 + i] : 8'hxx;
      checks++;
      if (ga !== exp_a[i] || gd !== exp_d[i]) begin
        failures++; $display("FAIL wrap%0d: addr %h data %h want %h %h", i, ga, gd, exp_a[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int o0, d0;
    bit seen, hit;
    logic [37:0] outs;
    logic [7:0] got;
    o0 = outq.size();
    m_out_ready = 1'b1;
    do_start(1'b0, 16'h0100, 16'd8);
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      if (outq.size() - o0 >= 3) hit = 1'b1;
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL rst_mid_progress: 3 bytes not seen within 100 cycles"); end
    #2;
    RST = 1'b1;
    d0 = done_cnt;
    #1;
    outs = {busy, done, mem_address, mem_read_signal, mem_write_signal, mem_data,
            s_in_ready, m_out_data, m_out_valid};
    checks++;
    if (outs !== 38'd0) begin failures++; $display("FAIL rst_mid_outputs: got %h want 0", outs); end
    repeat (2) tick();
    RST = 1'b0;
    repeat (3) tick();
    checks++;
    if (done_cnt != d0) begin failures++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", done_cnt - d0); end
    preload(16'h0300, 8'h33);
    preload(16'h0301, 8'h44);
    o0 = outq.size();
    do_start(1'b0, 16'h0300, 16'd2);
    wait_done(100, seen);
    checks++;
    if (!seen) begin failures++; $display("FAIL rst_post_done: no done within 100 cycles"); end
    tick();
    checks++;
    if (outq.size() - o0 != 2) begin failures++; $display("FAIL rst_post_count: got %0d want 2", outq.size() - o0); end
    got = (o0 < outq.size()) ? outq[o0] : 8'hxx;
    checks++;
    if (got !== 8'h33) begin failures++; $display("FAIL rst_post_byte0: got %h want 33", got); end
    got = (o0 + 1 < outq.size()) ? outq[o0 + 1] : 8'hxx;
    checks++;
    if (got !== 8'h44) begin failures++; $display("FAIL rst_post_byte1: got %h want 44", got); end
  endtask

  initial begin
    test_reset();
    test_read_burst();
    test_backpressure();
    test_write_burst();
    test_len_zero();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
